// File: rtl/ahbram_rst_pkg.sv
// AHB-RAM reset sequencer shared types.
// Sequencer phase encoding.
package ahbram_rst_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      IDLE,
      WAIT,
      ASSERT,
      RELEASE
   } state_e;

endpackage

// File: rtl/ahbram_rst_seq_if.sv
// Run-time reset request port of the AHB-RAM reset sequencer.
// The master holds req_valid and the fields until req_ready.
interface ahbram_rst_seq_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
);

   logic              req_valid;
   logic              req_ready;
   logic [CNT_W-1:0]  req_delay;
   logic [CNT_W-1:0]  req_hold;
   logic [NUM_CH-1:0] req_mask;

   modport master (
      output req_valid,
      output req_delay,
      output req_hold,
      output req_mask,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_delay,
      input  req_hold,
      input  req_mask,
      output req_ready
   );

endinterface

// File: rtl/ahbram_dn_cnt.sv
// Loadable down-counter used for the wait and hold phases.
// Load wins over enable; the count stops at zero.
module ahbram_dn_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         load,
   input  logic [W-1:0] val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (load)
         cnt <= val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ahbram_rst_seq.sv
// Multi-channel reset sequencer for the AHB-RAM subsystem.
// Power-on hold plus staggered release; run-time masked re-resets.
module ahbram_rst_seq
   import ahbram_rst_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter int STAGGER  = 2,
   parameter int DEF_HOLD = 5,
   parameter int SEQ_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   ahbram_rst_seq_if.slave   req,
   output logic [NUM_CH-1:0] rstn_o,
   output logic              busy,
   output logic              done,
   output logic [SEQ_W-1:0]  seq_cnt
);

   localparam int SW = (STAGGER > 0) ? $clog2(STAGGER + 1) : 1;
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [SW-1:0] S_RLD =
      (STAGGER > 0) ? SW'(STAGGER - 1) : '0;
   // Loaded on the last reset edge, so one extra count.
   localparam logic [CNT_W-1:0] POR_HOLD = CNT_W'(DEF_HOLD + 1);

   state_e            state, nxt;
   logic [NUM_CH-1:0] mask_q;
   logic [CNT_W-1:0]  hold_q;
   logic [CNT_W-1:0]  req_h;
   logic [SW-1:0]     scnt;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     hi;
   logic              zdone;
   logic              acc;
   logic              w_load, w_en, w_zero;
   logic              h_load, h_en, h_zero;
   logic [CNT_W-1:0]  h_val;
   logic              hc_load;
   logic [CNT_W-1:0]  hc_val;
   logic              go_low, rel_all, rel0, rel_idx;
   logic              fin, start_rel, step;
   logic [NUM_CH-1:0] rnx;

   assign req.req_ready = !rst && state == IDLE && !zdone;
   assign busy = rst || state != IDLE || zdone;
   assign acc = req.req_valid && req.req_ready;
   assign req_h = (req.req_hold == '0) ? CNT_W'(1) : req.req_hold;

   always_comb begin
      hi = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (mask_q[i]) hi = IW'(i);
   end

   ahbram_dn_cnt #(.W(CNT_W)) u_wait (
      .clk  (clk),
      .load (w_load),
      .val  (req.req_delay),
      .en   (w_en),
      .zero (w_zero)
   );

   assign hc_load = rst || h_load;
   assign hc_val = rst ? POR_HOLD : h_val;

   ahbram_dn_cnt #(.W(CNT_W)) u_hold (
      .clk  (clk),
      .load (hc_load),
      .val  (hc_val),
      .en   (h_en),
      .zero (h_zero)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ASSERT;
      else
         state <= nxt;
   end

   always_comb begin
      nxt       = state;
      w_load    = 1'b0;
      w_en      = 1'b0;
      h_load    = 1'b0;
      h_en      = 1'b0;
      h_val     = hold_q;
      go_low    = 1'b0;
      rel_all   = 1'b0;
      rel0      = 1'b0;
      rel_idx   = 1'b0;
      fin       = 1'b0;
      start_rel = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            if (acc && req.req_mask != '0) begin
               if (req.req_delay == '0) begin
                  nxt    = ASSERT;
                  h_load = 1'b1;
                  h_val  = req_h;
               end else begin
                  nxt    = WAIT;
                  w_load = 1'b1;
               end
            end
         end
         WAIT: begin
            if (w_zero) begin
               nxt    = ASSERT;
               go_low = 1'b1;
               h_load = 1'b1;
               // Fall edge already consumed one hold cycle.
               h_val  = hold_q - 1'b1;
            end else begin
               w_en = 1'b1;
            end
         end
         ASSERT: begin
            go_low = 1'b1;
            if (h_zero) begin
               if (STAGGER == 0 || hi == '0) begin
                  rel_all = 1'b1;
                  fin     = 1'b1;
                  nxt     = IDLE;
               end else begin
                  rel0      = 1'b1;
                  start_rel = 1'b1;
                  nxt       = RELEASE;
               end
            end else begin
               h_en = 1'b1;
            end
         end
         RELEASE: begin
            if (scnt == '0) begin
               rel_idx = 1'b1;
               if (idx == hi) begin
                  fin = 1'b1;
                  nxt = IDLE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      rnx = rstn_o;
      if (go_low)
         rnx = rnx & ~mask_q;
      if (rel_all)
         rnx = rnx | mask_q;
      if (rel0)
         rnx[0] = rnx[0] | mask_q[0];
      if (rel_idx)
         rnx[idx] = rnx[idx] | mask_q[idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rstn_o  <= '0;
         mask_q  <= '1;
         hold_q  <= CNT_W'(DEF_HOLD);
         done    <= 1'b0;
         zdone   <= 1'b0;
         seq_cnt <= '0;
         idx     <= '0;
         scnt    <= '0;
      end else begin
         rstn_o <= rnx;
         done   <= fin || zdone;
         // Empty mask: completion is reported one cycle after accept.
         zdone  <= acc && req.req_mask == '0;
         if ((fin || zdone) && seq_cnt != '1)
            seq_cnt <= seq_cnt + 1'b1;
         if (acc) begin
            mask_q <= req.req_mask;
            hold_q <= req_h;
         end
         if (start_rel) begin
            idx  <= IW'(1);
            scnt <= S_RLD;
         end else if (step) begin
            idx  <= idx + 1'b1;
            scnt <= S_RLD;
         end else if (state == RELEASE && scnt != '0) begin
            scnt <= scnt - 1'b1;
         end
      end
   end

endmodule
